// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//  Groups the fetch, decode and control handshakes of the PC sequencer.
//  master: the sequencer side (drives fetch_req, pc, epc, ir, ir_valid, pc_write).
//  slave : the environment side (instruction memory, register file, ALU, exception logic).
//  Signals:
//   instr_valid/instr  fetch acknowledge and instruction word
//   rs_data            register-file rs value (JR target)
//   branch_valid/taken branch compare result
//   exec_done          non-control instruction finished
//   exc/exc_cause      exception request and cause
//   fetch_req, pc, epc, ir, ir_valid, pc_write  sequencer outputs
interface pc_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic        branch_valid;
    logic        branch_taken;
    logic        exec_done;
    logic        exc;
    logic [1:0]  exc_cause;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        pc_write;

    modport master (
        input  instr_valid, instr, rs_data, branch_valid, branch_taken,
               exec_done, exc, exc_cause,
        output fetch_req, pc, epc, ir, ir_valid, pc_write
    );

    modport slave (
        output instr_valid, instr, rs_data, branch_valid, branch_taken,
               exec_done, exc, exc_cause,
        input  fetch_req, pc, epc, ir, ir_valid, pc_write
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//  Multicycle program-counter controller for the MIPS-subset core. Owns PC, EPC and
//  the instruction register; fetches through a valid handshake and selects the next
//  PC from PC+4, branch target, jump target, JR register or exception vector.
//  Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pc_sequencer_if.master (fetch, decode, branch/exec and exception signals)
//  Configuration:
//   PC_SEQ_ALIGN_CHK_EN  when defined, a JR to a non-word-aligned address raises an
//                        internal exception (cause 2'b11) instead of loading pc.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE = 32'h0000_0080,
    parameter logic [5:0]  OPC_J    = 6'h02,
    parameter logic [5:0]  OPC_JAL  = 6'h03,
    parameter logic [5:0]  OPC_BEQ  = 6'h04,
    parameter logic [5:0]  OPC_BNE  = 6'h05
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        WAIT_BR = 2'd2,
        WAIT_EX = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, epc, ir, pc_plus4;
    logic [31:0] pc_nxt;
    logic        pc_load, epc_load, take_exc;
    logic [1:0]  cause_sel;

    logic [5:0]  opcode;
    logic        is_jump, is_jr, is_branch;
    logic [31:0] jump_tgt, branch_tgt;

    assign opcode     = ir[31:26];
    assign is_jump    = (opcode == OPC_J) || (opcode == OPC_JAL);
    assign is_jr      = (opcode == 6'h00) && (ir[5:0] == 6'h08);
    assign is_branch  = (opcode == OPC_BEQ) || (opcode == OPC_BNE);
    assign jump_tgt   = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign branch_tgt = pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            epc      <= '0;
            ir       <= '0;
            pc_plus4 <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && bus.instr_valid) begin
                ir       <= bus.instr;
                pc_plus4 <= pc + 32'd4;
            end
            if (pc_load)  pc  <= pc_nxt;
            if (epc_load) epc <= pc;
        end
    end

    // Next-state and next-pc selection
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pc_load   = 1'b0;
        epc_load  = 1'b0;
        take_exc  = 1'b0;
        cause_sel = bus.exc_cause;

        unique case (state)
            FETCH: begin
                if (bus.instr_valid) state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = WAIT_EX;
                if (is_jump) begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    pc_nxt    = jump_tgt;
                end else if (is_jr) begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    pc_nxt    = bus.rs_data;
`ifdef PC_SEQ_ALIGN_CHK_EN
                    if (bus.rs_data[1:0] != 2'b00) begin
                        take_exc  = 1'b1;
                        cause_sel = 2'b11;
                    end
`endif
                end else if (is_branch) begin
                    state_nxt = WAIT_BR;
                end
            end
            WAIT_BR: begin
                if (bus.branch_valid) begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    pc_nxt    = bus.branch_taken ? branch_tgt : pc_plus4;
                end
            end
            WAIT_EX: begin
                if (bus.exec_done) begin
                    state_nxt = FETCH;
                    pc_load   = 1'b1;
                    pc_nxt    = pc_plus4;
                end
            end
            default: state_nxt = FETCH;
        endcase

        // External exception overrides every update above (and the internal
        // alignment exception's cause) outside FETCH.
        if (state != FETCH && bus.exc) begin
            take_exc  = 1'b1;
            cause_sel = bus.exc_cause;
        end

        if (take_exc) begin
            state_nxt = FETCH;
            pc_load   = 1'b1;
            epc_load  = 1'b1;
            pc_nxt    = EXC_BASE + {28'd0, cause_sel, 2'b00};
        end
    end

    // Outputs
    always_comb begin
        bus.fetch_req = (state == FETCH);
        bus.ir_valid  = (state == DECODE);
        bus.pc_write  = pc_load;
        bus.pc        = pc;
        bus.epc       = epc;
        bus.ir        = ir;
    end

endmodule
